// File: rtl/y_seq_div_pkg.sv
// Shared definitions for the sequential divider: default width and FSM state encoding.
package y_seq_div_pkg;

  localparam int DIV_DEFAULT_SIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/y_div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the shifted
// partial remainder, keeping the old value when the subtraction borrows.
module y_div_step #(
  parameter int SIZE = 32
) (
  input  logic [SIZE:0]   t,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] r_out,
  output logic            q_lsb
);

  logic [SIZE:0] diff;

  // Trial subtract in SIZE+1 bits; the top bit is the borrow that selects restore.
  always_comb begin
    diff  = t - {1'b0, d};
    q_lsb = ~diff[SIZE];
    r_out = diff[SIZE] ? t[SIZE-1:0] : diff[SIZE-1:0];
  end

endmodule

// File: rtl/y_seq_div.sv
// Multi-cycle restoring divider with a start/done handshake.
// Optional feature: define DIV_SIGNED_EN for two's-complement operands
// (magnitudes divided, signs fixed up when the result is published).
module y_seq_div
  import y_seq_div_pkg::*;
#(
  parameter int SIZE = DIV_DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero
);

  // Handshake: start is only looked at while busy is low (IDLE); a sampled start
  // captures the operands. busy covers RUN and DONE, and done pulses for one cycle
  // right after that, with quotient/remainder/div_by_zero valid from the done
  // cycle and held until the next result is published.

  localparam int CNT_W = $clog2(SIZE + 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] r_q, r_d;
  logic [SIZE-1:0] q_q, q_d;
  logic [SIZE-1:0] d_q, d_d;
  logic            dbz_q, dbz_d;
  logic            done_q, done_d;
  logic [SIZE-1:0] quot_q, quot_d;
  logic [SIZE-1:0] rem_q, rem_d;
  logic            dbzo_q, dbzo_d;
`ifdef DIV_SIGNED_EN
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
`endif

  logic [SIZE-1:0] step_r;
  logic            step_q;

  y_div_step #(.SIZE(SIZE)) u_step (
    .t     ({r_q, q_q[SIZE-1]}),
    .d     (d_q),
    .r_out (step_r),
    .q_lsb (step_q)
  );

  // Next-state, datapath and output-register updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbzo_d  = dbzo_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // No iterations needed: the fixed divide-by-zero answer goes straight to DONE.
            r_d     = dividend;
            q_d     = '1;
            d_d     = '0;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
`ifdef DIV_SIGNED_EN
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
`endif
          end else begin
            r_d     = '0;
            dbz_d   = 1'b0;
            cnt_d   = CNT_W'(SIZE);
            state_d = ST_RUN;
`ifdef DIV_SIGNED_EN
            q_d     = dividend[SIZE-1] ? ('0 - dividend) : dividend;
            d_d     = divisor[SIZE-1] ? ('0 - divisor) : divisor;
            qneg_d  = dividend[SIZE-1] ^ divisor[SIZE-1];
            rneg_d  = dividend[SIZE-1];
`else
            q_d     = dividend;
            d_d     = divisor;
`endif
          end
        end
      end
      ST_RUN: begin
        r_d   = step_r;
        q_d   = {q_q[SIZE-2:0], step_q};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        dbzo_d  = dbz_q;
`ifdef DIV_SIGNED_EN
        quot_d  = qneg_q ? ('0 - q_q) : q_q;
        rem_d   = rneg_q ? ('0 - r_q) : r_q;
`else
        quot_d  = q_q;
        rem_d   = r_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbzo_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbzo_q  <= dbzo_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbzo_q;

endmodule

// File: tb/tb_y_seq_div.sv
// Self-checking bench for y_seq_div: directed cases plus random traffic
// compared every cycle against a behavioural division model.
module tb_y_seq_div;

  localparam int W      = 32;
  localparam int BUDGET = 80;
`ifdef DIV_SIGNED_EN
  localparam int N_RAND = 1000;
`else
  localparam int N_RAND = 400;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  y_seq_div #(.SIZE(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Returns {div_by_zero, quotient, remainder} from plain arithmetic.
  function automatic logic [2*W:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) begin
      q = '1;
      r = a;
      return {1'b1, q, r};
    end
`ifdef DIV_SIGNED_EN
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
`else
    q = a / b;
    r = a % b;
`endif
    return {1'b0, q, r};
  endfunction

  logic [2*W:0] exp_q[$];
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_quot = '0;
  logic [W-1:0] m_rem  = '0;
  logic         m_dbz  = 1'b0;
  logic         m_live = 1'b0;

  // Model: an accepted start keeps the unit busy SIZE+1 cycles (1 for divide-by-zero),
  // then the queued result is published with a one-cycle done.
  always @(posedge clk) begin
    logic       was_idle;
    logic [2*W:0] r;
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_quot = '0;
      m_rem  = '0;
      m_dbz  = 1'b0;
      exp_q.delete();
      m_live = 1'b1;
    end else begin
      was_idle = (m_left == 0);
      m_done   = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0 && exp_q.size() > 0) begin
          r = exp_q.pop_front();
          {m_dbz, m_quot, m_rem} = r;
          m_done = 1'b1;
        end
      end
      if (was_idle && start) begin
        exp_q.push_back(model_div(dividend, divisor));
        m_left = (divisor == '0) ? 1 : W + 1;
      end
    end
  end

  // Compare process: busy/done every cycle, results whenever the unit is idle.
  always @(negedge clk) begin
    if (m_live) begin
      check("busy", W'(busy), W'(m_left != 0));
      check("done", W'(done), W'(m_done));
      if (m_left == 0) begin
        check("quotient", quotient, m_quot);
        check("remainder", remainder, m_rem);
        check("div_by_zero", W'(div_by_zero), W'(m_dbz));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one division from idle; lat counts clock edges from acceptance to done.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    lat = -1; busy_cnt = 0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; dividend = $urandom; divisor = $urandom;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = k - 1;
        break;
      end
    end
    if (lat < 0) check("done_timeout", W'(done), W'(1));
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return W'($urandom_range(0, 20));
      1: return 32'hFFFF_FFF0 | W'($urandom_range(0, 15));
      2: return W'(1) << $urandom_range(0, W - 1);
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int bcnt;
    int seen;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int stop_at;
    logic abort;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_quot", quotient, W'(0));
    check("rst_rem", remainder, W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7
    do_div(32'd100, 32'd7, lat, bcnt);
    check("t1_lat", W'(lat), W'(W + 1));
    check("t1_busy_cycles", W'(bcnt), W'(33));
    check("t1_quot", quotient, 32'd14);
    check("t1_rem", remainder, 32'd2);
    check("t1_dbz", W'(div_by_zero), W'(0));

    // 5 / 0
    do_div(32'd5, 32'd0, lat, bcnt);
    check("t2_lat", W'(lat), W'(1));
    check("t2_quot", quotient, 32'hFFFF_FFFF);
    check("t2_rem", remainder, 32'd5);
    check("t2_dbz", W'(div_by_zero), W'(1));

    // all-ones / 1 and small / large
    do_div(32'hFFFF_FFFF, 32'd1, lat, bcnt);
    check("t3_quot", quotient, 32'hFFFF_FFFF);
    check("t3_rem", remainder, 32'd0);
    do_div(32'd3, 32'd10, lat, bcnt);
    check("t4_quot", quotient, 32'd0);
    check("t4_rem", remainder, 32'd3);

    // start while busy is dropped
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < BUDGET && !done; k++) @(negedge clk);
    check("t5_drop_done", W'(done), W'(1));
    check("t5_drop_quot", quotient, 32'd14);
    check("t5_drop_rem", remainder, 32'd2);

    // reset mid-run aborts with no done
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_rst_busy", W'(busy), W'(0));
    check("t5_rst_quot", quotient, W'(0));
    check("t5_rst_rem", remainder, W'(0));
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("t5_no_done", W'(seen), W'(0));
    do_div(32'd9, 32'd3, lat, bcnt);
    check("t5_new_quot", quotient, 32'd3);
    check("t5_new_rem", remainder, 32'd0);

`ifdef DIV_SIGNED_EN
    do_div(-32'sd7, 32'd2, lat, bcnt);
    check("t6_a_quot", quotient, -32'sd3);
    check("t6_a_rem", remainder, -32'sd1);
    do_div(32'd7, -32'sd2, lat, bcnt);
    check("t6_b_quot", quotient, -32'sd3);
    check("t6_b_rem", remainder, 32'd1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    check("t6_ovf_quot", quotient, 32'h8000_0000);
    check("t6_ovf_rem", remainder, 32'd0);
    check("t6_ovf_dbz", W'(div_by_zero), W'(0));
    do_div(-32'sd9, 32'd0, lat, bcnt);
    check("t6_dbz_quot", quotient, 32'hFFFF_FFFF);
    check("t6_dbz_rem", remainder, -32'sd9);
`endif

    // random traffic: back-to-back starts, stray starts while busy, occasional aborts
    @(negedge clk);
    for (int i = 0; i < N_RAND; i++) begin
      a = rand_operand();
      b = ($urandom_range(0, 9) == 0) ? '0 : rand_operand();
      start = 1'b1; dividend = a; divisor = b;
      abort = ($urandom_range(0, 39) == 0);
      stop_at = $urandom_range(2, 30);
      for (int k = 1; k <= BUDGET; k++) begin
        @(negedge clk);
        start = ($urandom_range(0, 7) == 0);
        dividend = $urandom; divisor = $urandom;
        if (abort && k == stop_at) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          break;
        end
        if (done) break;
      end
      start = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (W + 4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
